// File: rtl/product_shift_register.sv
// Multicycle product register: one shift-add (or radix-2 Booth) step per clock over WIDTH cycles.
// Define PRODUCT_SIGNED_BOOTH_EN for signed Booth operation; the default build is unsigned shift-add.
module product_shift_register #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               res,
   input  logic               start,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] mcand;
   logic [CW-1:0]    count;
   logic [WIDTH:0]   sum;
   logic             last;

   assign last = (count == CW'(WIDTH - 1));

   always_comb begin
      state_nxt = state;
      busy      = (state != IDLE);
      done      = (state == DONE);
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last)  state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

`ifdef PRODUCT_SIGNED_BOOTH_EN
   logic           q_m1;
   logic [WIDTH:0] hi_ext, mc_ext;

   // Upper half widened by one sign bit so subtracting the most negative mcand cannot overflow.
   always_comb begin
      hi_ext = {product[2*WIDTH-1], product[2*WIDTH-1:WIDTH]};
      mc_ext = {mcand[WIDTH-1], mcand};
      case ({product[0], q_m1})
         2'b01:   sum = hi_ext + mc_ext;
         2'b10:   sum = hi_ext - mc_ext;
         default: sum = hi_ext;
      endcase
   end

   always_ff @(posedge clk or posedge res) begin
      if (res) q_m1 <= 1'b0;
      else if (state == IDLE && start) q_m1 <= 1'b0;
      else if (state == RUN) q_m1 <= product[0];
   end
`else
   always_comb begin
      sum = {1'b0, product[2*WIDTH-1:WIDTH]} + (product[0] ? {1'b0, mcand} : '0);
   end
`endif

   // The shifted-out bit of {sum, lower} is dropped; sum[WIDTH] lands in the product MSB,
   // which is the carry (unsigned) or the sign (Booth) as appropriate.
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state   <= IDLE;
         product <= '0;
         mcand   <= '0;
         count   <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: if (start) begin
               mcand   <= multiplicand;
               product <= {{WIDTH{1'b0}}, multiplier};
               count   <= '0;
            end
            RUN: begin
               product <= {sum, product[WIDTH-1:1]};
               count   <= count + CW'(1);
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_product_shift_register.sv
// Scoreboard bench: expected products queued at start, compared when done pulses (WIDTH 32 and 8).
module tb_product_shift_register;
   logic        clk = 1'b0;
   logic        res = 1'b0;
   logic        start = 1'b0;
   logic [31:0] m_a = '0, m_b = '0;
   logic        busy, done;
   logic [63:0] product;
   logic        s8 = 1'b0;
   logic [7:0]  a8 = '0, b8 = '0;
   logic        busy8, done8;
   logic [15:0] p8;

   int n_chk = 0, n_pass = 0;
   logic [63:0] q32[$];
   logic [15:0] q8[$];

   always #5 clk = ~clk;

   product_shift_register #(.WIDTH(32)) dut (
      .clk(clk), .res(res), .start(start), .multiplicand(m_a), .multiplier(m_b),
      .busy(busy), .done(done), .product(product));

   product_shift_register #(.WIDTH(8)) dut8 (
      .clk(clk), .res(res), .start(s8), .multiplicand(a8), .multiplier(b8),
      .busy(busy8), .done(done8), .product(p8));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   function automatic logic [63:0] model32(input logic [31:0] a, input logic [31:0] b);
`ifdef PRODUCT_SIGNED_BOOTH_EN
      logic signed [63:0] sa, sb;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      return sa * sb;
`else
      return {32'b0, a} * {32'b0, b};
`endif
   endfunction

   function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b);
`ifdef PRODUCT_SIGNED_BOOTH_EN
      logic signed [15:0] sa, sb;
      sa = {{8{a[7]}}, a};
      sb = {{8{b[7]}}, b};
      return sa * sb;
`else
      return {8'b0, a} * {8'b0, b};
`endif
   endfunction

   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (q32.size() == 0) chk("sb32_empty", 64'd1, 64'd0);
         else chk("prod32", product, q32.pop_front());
      end
      if (done8 === 1'b1) begin
         if (q8.size() == 0) chk("sb8_empty", 64'd1, 64'd0);
         else chk("prod8", 64'(p8), 64'(q8.pop_front()));
      end
   end

   // inj_run: cycle at which a spurious start (5*5) is pulsed during RUN; inj_done: pulse in DONE.
   task automatic go32(input logic [31:0] a, input logic [31:0] b, input int inj_run, input bit inj_done);
      int cyc;
      @(negedge clk);
      m_a = a; m_b = b; start = 1'b1;
      q32.push_back(model32(a, b));
      @(negedge clk);
      start = 1'b0;
      chk("busy_run", 64'(busy), 64'd1);
      cyc = 1;
      while (done !== 1'b1 && cyc < 100) begin
         if (cyc == inj_run) begin start = 1'b1; m_a = 32'd5; m_b = 32'd5; end
         @(negedge clk);
         start = 1'b0;
         cyc++;
      end
      chk("lat32", 64'(cyc), 64'd33);
      if (inj_done) begin start = 1'b1; m_a = 32'd5; m_b = 32'd5; end
      @(negedge clk);
      start = 1'b0;
      chk("pulse32", 64'(done), 64'd0);
      chk("idle32", 64'(busy), 64'd0);
      chk("hold32", product, model32(a, b));
   endtask

   task automatic go8(input logic [7:0] a, input logic [7:0] b);
      int cyc;
      @(negedge clk);
      a8 = a; b8 = b; s8 = 1'b1;
      q8.push_back(model8(a, b));
      @(negedge clk);
      s8 = 1'b0;
      cyc = 1;
      while (done8 !== 1'b1 && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      chk("lat8", 64'(cyc), 64'd9);
      @(negedge clk);
      chk("pulse8", 64'(done8), 64'd0);
   endtask

   logic [31:0] va[8] = '{32'hFFFFFFFF, 32'h00000000, 32'h00000001, 32'hFFFFFFFD,
                          32'h80000000, 32'hFFFFFFFF, 32'h0001_0000, 32'h7FFFFFFF};
   logic [31:0] vb[8] = '{32'hFFFFFFFF, 32'h12345678, 32'h89ABCDEF, 32'h00000007,
                          32'h80000000, 32'hFFFFFFFF, 32'h0001_0000, 32'h80000001};

   initial begin
      #1 res = 1'b1;
      #3;
      chk("rst_prod", product, 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      @(negedge clk);
      res = 1'b0;

      foreach (va[i]) go32(va[i], vb[i], -1, 1'b0);
      for (int i = 0; i < 3; i++) go32($urandom, $urandom, -1, 1'b0);

      // 7*9 with spurious starts in RUN and DONE, then a genuine 5*5
      go32(32'd7, 32'd9, 10, 1'b1);
      go32(32'd5, 32'd5, -1, 1'b0);

      // Abort mid-run: reset clears everything at once, nothing is queued for the aborted op
      @(negedge clk);
      m_a = 32'h1234; m_b = 32'h5678; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (11) @(negedge clk);
      res = 1'b1;
      #1;
      chk("abort_prod", product, 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      @(negedge clk);
      res = 1'b0;
      go32(32'hDEADBEEF, 32'h0000_0003, -1, 1'b0);

      go8(8'd200, 8'd200);
      go8(8'd255, 8'd1);
      go8(8'd128, 8'd3);

      repeat (3) @(negedge clk);
      chk("sb32_drained", 64'(q32.size()), 64'd0);
      chk("sb8_drained", 64'(q8.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
